// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests into a DEPTH-entry
// instruction buffer; a redirect empties the buffer and drains stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d, stale_q, stale_d, count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  entry_t        buf_q [DEPTH];
  entry_t        buf_d [DEPTH];
  logic          redir, req_fire, rsp_dec, push, pop;
  logic [CW:0]   credit_used;
  logic [31:0]   target_pc;
  logic          redirect_lsb_unused;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outstanding requests plus buffered words never exceed DEPTH, so every
  // response accepted in RUN is guaranteed a free buffer slot.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == RUN) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr          = buf_q[head_q].data;
  assign instr_pc       = buf_q[head_q].pc;
  assign instr_pc_plus4 = buf_q[head_q].pc + 32'd4;

  assign target_pc           = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    stale_d    = stale_q;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_d      = buf_q;

    redir    = redirect_valid && (state_q != IDLE);
    req_fire = imem_req_valid && imem_req_ready;
    rsp_dec  = imem_rsp_valid && (outst_q != '0);
    push     = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
    pop      = instr_valid && instr_ready;

    outst_d = outst_q + CW'(req_fire) - CW'(rsp_dec);
    count_d = count_q + CW'(push) - CW'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push) begin
      buf_d[tail_q] = '{pc: rsp_pc_q, data: imem_rsp_data};
      tail_d        = ptr_inc(tail_q);
      rsp_pc_d      = rsp_pc_q + 32'd4;
    end
    if (pop) head_d = ptr_inc(head_q);

    case (state_q)
      IDLE:  state_d = RUN;
      RUN:   state_d = RUN;
      FLUSH: begin
        if (imem_rsp_valid && (stale_q != '0)) stale_d = stale_q - CW'(1);
        if (stale_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Responses still in flight belong to the old path; count them so
    // FLUSH can drop exactly that many before fetching resumes.
    if (redir) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      stale_d    = outst_q - CW'(rsp_dec);
      state_d    = (stale_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q      <= buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: scenarios queue expected requests and
// instructions; a negedge monitor pops and compares as the DUT presents them.
module tb_fetch_unit;
  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr, instr_pc, instr_pc_plus4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] pc4;
  } ins_t;

  logic [31:0] exp_req[$];
  ins_t        exp_ins[$];
  logic [31:0] pend[$];
  int          n_chk = 0, n_err = 0, n_fire = 0, fire_limit = 0;
  logic        rsp_hold;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      32'h0000_0008: return 32'h0020_81b3;
      32'h0000_000c: return 32'h4011_0233;
      32'h0000_0100: return 32'h0ff0_0293;
      32'h0000_0104: return 32'h0012_8313;
      32'h0000_0200: return 32'h00c0_03ef;
      32'h0000_0300: return 32'h0043_0413;
      32'h0000_0304: return 32'h0054_0493;
      32'hffff_fffc: return 32'h0000_006f;
      default:       return 32'hbad0_0013;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Memory: one-cycle latency, accepts while under the scenario's fire budget.
  always @(posedge clk) begin
    #1;
    imem_req_ready = (n_fire < fire_limit);
    if (!rsp_hold && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Inputs are stable from posedge+1 to the next posedge, so a negedge
  // sample sees exactly what the DUT commits on the coming edge.
  always @(negedge clk) begin : mon
    ins_t e;
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        n_fire++;
        if (exp_req.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL req_unexpected: got addr %h, none expected", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, exp_req.pop_front());
        end
        pend.push_back(imem_req_addr);
      end
      if (instr_valid && instr_ready) begin
        if (exp_ins.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL instr_unexpected: got pc %h instr %h, none expected", instr_pc, instr);
        end else begin
          e = exp_ins.pop_front();
          chk("instr", instr, e.data);
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_pc_plus4", instr_pc_plus4, e.pc4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; rsp_hold = 1'b0;
    fire_limit = n_fire;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_fires(int k);
    int tgt;
    tgt = n_fire + k;
    for (int i = 0; i < 40 && n_fire < tgt; i++) step();
    chk("fire_count", 32'(n_fire), 32'(tgt));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_req.size() > 0 || exp_ins.size() > 0); i++) step();
    repeat (3) step();
    chk("req_queue_left", 32'(exp_req.size()), 32'd0);
    chk("ins_queue_left", 32'(exp_ins.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0000_0000);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_instr_pc_plus4"}, instr_pc_plus4, 32'h4);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    rsp_hold = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset state, then streaming fetch with a one-cycle memory.
    step(); step();
    @(negedge clk);
    chk_reset_outputs("reset");
    step();
    instr_ready = 1'b1;
    fire_limit  = n_fire + 4;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_req.push_back(32'h8); exp_req.push_back(32'hc);
    exp_ins.push_back('{32'h0, 32'h0050_0093, 32'h4});
    exp_ins.push_back('{32'h4, 32'h00a0_0113, 32'h8});
    exp_ins.push_back('{32'h8, 32'h0020_81b3, 32'hc});
    exp_ins.push_back('{32'hc, 32'h4011_0233, 32'h10});
    rst_n = 1'b1;
    wait_drain();
    // Memory stops accepting: request must hold its address.
    @(negedge clk);
    chk("hold_valid_a", 32'(imem_req_valid), 32'd1);
    chk("hold_addr_a", imem_req_addr, 32'h10);
    step(); step();
    @(negedge clk);
    chk("hold_valid_b", 32'(imem_req_valid), 32'd1);
    chk("hold_addr_b", imem_req_addr, 32'h10);

    // Decode stalled: credit limit caps requests at DEPTH until a pop.
    do_reset();
    fire_limit = n_fire + 2;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    wait_fires(2);
    repeat (4) step();
    @(negedge clk);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_instr", instr, 32'h0050_0093);
    step();
    fire_limit = n_fire + 1;
    exp_req.push_back(32'h8);
    exp_ins.push_back('{32'h0, 32'h0050_0093, 32'h4});
    instr_ready = 1'b1;
    @(negedge clk);
    chk("prepop_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    instr_ready = 1'b0;
    wait_drain();

    // Redirect with two in flight: both stale responses dropped.
    do_reset();
    instr_ready = 1'b1; rsp_hold = 1'b1;
    fire_limit  = n_fire + 2;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    wait_fires(2);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0; rsp_hold = 1'b0;
    fire_limit = n_fire + 2;
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    exp_ins.push_back('{32'h100, 32'h0ff0_0293, 32'h104});
    exp_ins.push_back('{32'h104, 32'h0012_8313, 32'h108});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_req_valid", 32'(imem_req_valid), 32'd0);
      chk("flush_instr_valid", 32'(instr_valid), 32'd0);
      step();
    end
    wait_drain();

    // Redirect coinciding with the only outstanding response.
    do_reset();
    instr_ready = 1'b1;
    fire_limit  = n_fire + 1;
    exp_req.push_back(32'h0);
    wait_fires(1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    exp_req.push_back(32'h200);
    exp_ins.push_back('{32'h200, 32'h00c0_03ef, 32'h204});
    step();
    redirect_valid = 1'b0;
    fire_limit = n_fire + 1;
    @(negedge clk);
    chk("coinc_instr_valid", 32'(instr_valid), 32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    wait_drain();

    // Asynchronous reset with a full buffer and nothing in flight.
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    fire_limit = n_fire + 2;
    exp_req.push_back(32'h300); exp_req.push_back(32'h304);
    wait_fires(2);
    repeat (3) step();
    chk("prereset_instr_valid", 32'(instr_valid), 32'd1);
    chk("prereset_instr_pc", instr_pc, 32'h300);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    step(); step();
    rst_n = 1'b1;
    fire_limit = n_fire + 1;
    exp_req.push_back(32'h0);
    wait_drain();

    // Fetch address wraps past the top of the address space.
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    step();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    fire_limit = n_fire + 2;
    exp_req.push_back(32'hffff_fffc); exp_req.push_back(32'h0);
    exp_ins.push_back('{32'hffff_fffc, 32'h0000_006f, 32'h0});
    exp_ins.push_back('{32'h0, 32'h0050_0093, 32'h4});
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction buffer entries, which also sets the outstanding-request limit.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed in REQ-004 to REQ-016.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts the request.
REQ-008 imem_req_addr  out  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  in  1  in-order response valid; always accepted.
REQ-010 imem_rsp_data  in  32  instruction word.
REQ-011 redirect_valid  in  1  taken branch/jump (pc_source) from the control path.
REQ-012 redirect_pc  in  32  branch/jump target.
REQ-013 instr_valid  out  1  instruction available to decode.
REQ-014 instr_ready  in  1  decode consumes the instruction.
REQ-015 instr  out  32  instruction (op/func3/func7 source).
REQ-016 instr_pc, instr_pc_plus4  out  32 each  instruction address and that address + 4.

Function
REQ-017 Request handshake: a request SHALL transfer on a cycle with imem_req_valid=1 and imem_req_ready=1; addr SHALL hold stable while valid=1 and ready=0.
REQ-018 The block SHALL keep fetch_pc; each accepted request SHALL advance it by 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
REQ-019 Credit rule: imem_req_valid SHALL be 1 only in RUN, when redirect_valid=0, and when outstanding + buffer_count < DEPTH.
REQ-020 Responses SHALL be accepted unconditionally, in order; in RUN each response SHALL be written to the buffer with its request address; the credit rule guarantees space.
REQ-021 Latency: a response arriving in cycle N SHALL present instr_valid=1 in cycle N+1 at the earliest; no combinational path from imem_rsp_* to instr_*.
REQ-022 instr_valid SHALL equal "buffer not empty"; the head entry SHALL pop when instr_valid and instr_ready are both 1; push and pop in the same cycle SHALL keep the count unchanged.
REQ-023 instr_pc_plus4 SHALL equal instr_pc + 4, modulo 2^32.
REQ-024 FSM states SHALL be IDLE, RUN, and FLUSH.
REQ-025 IDLE: entered on reset; no request; SHALL move to RUN on the next edge.
REQ-026 RUN: normal fetch.
REQ-027 On redirect_valid=1 in RUN or FLUSH, the block SHALL, in that cycle:
  - set fetch_pc to {redirect_pc[31:2],2'b00};
  - clear the buffer, and treat a pop in the same cycle as completed;
  - set stale = outstanding - (response this cycle ? 1 : 0);
  - go to FLUSH if stale > 0, else RUN.
REQ-028 FLUSH: no requests; each response SHALL be discarded and decrement stale; stale reaching 0 SHALL move to RUN on the next edge.
REQ-029 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-030 outstanding SHALL be incremented on request accept and decremented on response, both in the same cycle giving no change; it SHALL never exceed DEPTH.

Reset
REQ-031 While rst_n=0, independent of clk:
  - imem_req_valid=0, instr_valid=0;
  - imem_req_addr=RESET_PC, instr=0, instr_pc=0, instr_pc_plus4=4;
  - fetch_pc=RESET_PC; buffer, outstanding and stale=0; state=IDLE.
REQ-032 Reset asserted mid-operation SHALL drop all buffered and in-flight work; responses to pre-reset requests are the memory's responsibility to cancel.

Verification
REQ-033 Reset release with ready=1 and 1-cycle memory returning 0x00500093 at 0x0 -> requests 0x0 then 0x4; instr=0x00500093, instr_pc=0x0, instr_pc_plus4=0x4.
REQ-034 instr_ready=0 held -> exactly 2 requests (0x0, 0x4), then imem_req_valid=0 until one pop, then request 0x8.
REQ-035 Two requests outstanding, redirect_pc=0x103 -> FLUSH; both responses discarded and instr_valid stays 0; next request 0x100, then 0x104.
REQ-036 Redirect in the same cycle as a response with outstanding=1 -> response discarded, state RUN next cycle, request at the target.
REQ-037 rst_n low while buffer=2 and outstanding=0 -> outputs take reset values immediately without a clock edge; after release the first request is RESET_PC.
REQ-038 fetch_pc=0xFFFF_FFFC accepted -> next request 0x0000_0000; that entry shows instr_pc_plus4=0x0000_0000.
